// File: rtl/status_register_bank.sv
// Bank of software-accessible status registers with sticky hardware event bits,
// a per-bit read-only mask and a single tagged request/response port.
module status_register_bank #(
  parameter int unsigned WORD_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned TAG_WIDTH  = 1,
  localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH,
  parameter logic [NUM_REGS*WORD_WIDTH-1:0] RO_MASK = '0
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic [TAG_WIDTH-1:0]           i_tag,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic [WORD_WIDTH-1:0]          i_data,
  input  logic [1:0]                     i_op,
  input  logic                           i_valid,
  input  logic                           i_halt,
  input  logic [NUM_REGS*WORD_WIDTH-1:0] i_hw_set,
  output logic [TAG_WIDTH-1:0]           o_tag,
  output logic [WORD_WIDTH-1:0]          o_data,
  output logic [1:0]                     o_op,
  output logic                           o_valid,
  output logic                           o_freeze_inputs
);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  localparam logic [NUM_REGS-1:0][WORD_WIDTH-1:0] RoMask = RO_MASK;

  logic [NUM_REGS-1:0][WORD_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0][WORD_WIDTH-1:0] hw_set;
  logic                                accept;

  assign hw_set          = i_hw_set;
  assign accept          = i_valid & ~i_halt;
  assign o_freeze_inputs = i_halt;

  always_comb begin
    logic [WORD_WIDTH-1:0] sw_next;
    logic [WORD_WIDTH-1:0] wmask;
    regs_d  = regs_q;
    sw_next = '0;
    wmask   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sw_next = regs_q[r];
      wmask   = ~RoMask[r];
      if (accept && (i_addr == ADDR_WIDTH'(r))) begin
        case (i_op)
          OpRead:  sw_next = regs_q[r];
          OpWrite: sw_next = (regs_q[r] & ~wmask) | (i_data & wmask);
          OpSet:   sw_next = regs_q[r] | (i_data & wmask);
          OpClear: sw_next = regs_q[r] & ~(i_data & wmask);
          default: sw_next = regs_q[r];
        endcase
      end
      // Hardware events are ORed last so a same-cycle software clear never loses one.
      regs_d[r] = sw_next | hw_set[r];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      regs_q  <= '0;
      o_tag   <= '0;
      o_data  <= '0;
      o_op    <= '0;
      o_valid <= 1'b0;
    end else begin
      regs_q <= regs_d;
      if (!i_halt) begin
        o_valid <= accept;
        if (accept) begin
          o_tag  <= i_tag;
          o_data <= regs_q[i_addr];
          o_op   <= i_op;
        end
      end
    end
  end

endmodule

// File: tb/tb_status_register_bank.sv
// Directed bench for status_register_bank: one unmasked instance and one with
// bits [3:0] of register 2 read-only, both driven by the same stimulus.
module tb_status_register_bank;

  localparam int unsigned WW = 12;
  localparam int unsigned AW = 3;
  localparam int unsigned TW = 1;
  localparam int unsigned NR = 8;
  localparam logic [NR*WW-1:0] RoMaskReg2 = 96'h0000_0000_0000_0000_0F00_0000;

  logic            clk = 1'b0;
  logic            srst;
  logic [TW-1:0]   i_tag;
  logic [AW-1:0]   i_addr;
  logic [WW-1:0]   i_data;
  logic [1:0]      i_op;
  logic            i_valid;
  logic            i_halt;
  logic [NR*WW-1:0] i_hw_set;

  logic [TW-1:0] o_tag, r_tag;
  logic [WW-1:0] o_data, r_data;
  logic [1:0]    o_op, r_op;
  logic          o_valid, r_valid;
  logic          o_freeze, r_freeze;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  status_register_bank #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .srst(srst), .i_tag(i_tag), .i_addr(i_addr), .i_data(i_data), .i_op(i_op),
    .i_valid(i_valid), .i_halt(i_halt), .i_hw_set(i_hw_set), .o_tag(o_tag),
    .o_data(o_data), .o_op(o_op), .o_valid(o_valid), .o_freeze_inputs(o_freeze)
  );

  status_register_bank #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .RO_MASK(RoMaskReg2)
  ) dut_ro (
    .clk(clk), .srst(srst), .i_tag(i_tag), .i_addr(i_addr), .i_data(i_data), .i_op(i_op),
    .i_valid(i_valid), .i_halt(i_halt), .i_hw_set(i_hw_set), .o_tag(r_tag),
    .o_data(r_data), .o_op(r_op), .o_valid(r_valid), .o_freeze_inputs(r_freeze)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [WW-1:0] data, input logic [TW-1:0] tag);
    i_valid = 1'b1;
    i_op    = op;
    i_addr  = addr;
    i_data  = data;
    i_tag   = tag;
  endtask

  task automatic idle();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1; i_halt = 1'b0; i_hw_set = '0;
    drive(2'b01, 3'd0, 12'hFFF, 1'b1);
    tick(); tick();
    vectors++; if (o_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", o_valid); errors++; end
    vectors++; if (o_data !== 12'h000) begin $display("FAIL reset_data got %h want 000", o_data); errors++; end
    vectors++; if (o_tag !== 1'b0) begin $display("FAIL reset_tag got %b want 0", o_tag); errors++; end
    vectors++; if (o_op !== 2'b00) begin $display("FAIL reset_op got %b want 00", o_op); errors++; end
    vectors++; if (r_valid !== 1'b0) begin $display("FAIL reset_ro_valid got %b want 0", r_valid); errors++; end
    srst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_read_after_reset();
    drive(2'b00, 3'd5, 12'h123, 1'b1);
    tick();
    vectors++; if (o_valid !== 1'b1) begin $display("FAIL rd5_valid got %b want 1", o_valid); errors++; end
    vectors++; if (o_data !== 12'h000) begin $display("FAIL rd5_data got %h want 000", o_data); errors++; end
    vectors++; if (o_tag !== 1'b1) begin $display("FAIL rd5_tag got %b want 1", o_tag); errors++; end
    vectors++; if (o_op !== 2'b00) begin $display("FAIL rd5_op got %b want 00", o_op); errors++; end
    idle();
    tick();
    vectors++; if (o_valid !== 1'b0) begin $display("FAIL idle_valid got %b want 0", o_valid); errors++; end
    vectors++; if (o_tag !== 1'b1) begin $display("FAIL idle_tag_hold got %b want 1", o_tag); errors++; end
  endtask

  task automatic test_write_read();
    // The event pulse seeds the read-only low nibble of reg 2 in dut_ro.
    drive(2'b01, 3'd2, 12'hABC, 1'b0);
    i_hw_set[2*WW +: WW] = 12'h00C;
    tick();
    i_hw_set = '0;
    vectors++; if (o_data !== 12'h000) begin $display("FAIL wr2_data got %h want 000", o_data); errors++; end
    vectors++; if (o_op !== 2'b01) begin $display("FAIL wr2_op got %b want 01", o_op); errors++; end
    vectors++; if (o_tag !== 1'b0) begin $display("FAIL wr2_tag got %b want 0", o_tag); errors++; end
    drive(2'b00, 3'd2, 12'h000, 1'b1);
    tick();
    vectors++; if (o_data !== 12'hABC) begin $display("FAIL rd2_data got %h want ABC", o_data); errors++; end
    vectors++; if (r_data !== 12'hABC) begin $display("FAIL rd2_ro_data got %h want ABC", r_data); errors++; end
  endtask

  task automatic test_set_clear();
    drive(2'b10, 3'd2, 12'h003, 1'b0);
    tick();
    vectors++; if (o_data !== 12'hABC) begin $display("FAIL set_resp got %h want ABC", o_data); errors++; end
    drive(2'b11, 3'd2, 12'h0B0, 1'b1);
    tick();
    vectors++; if (o_data !== 12'hABF) begin $display("FAIL clr_resp got %h want ABF", o_data); errors++; end
    vectors++; if (r_data !== 12'hABC) begin $display("FAIL clr_ro_resp got %h want ABC", r_data); errors++; end
    drive(2'b00, 3'd2, 12'h000, 1'b0);
    tick();
    vectors++; if (o_data !== 12'hA0F) begin $display("FAIL setclr_rd got %h want A0F", o_data); errors++; end
    vectors++; if (r_data !== 12'hA0C) begin $display("FAIL setclr_ro_rd got %h want A0C", r_data); errors++; end
  endtask

  task automatic test_hw_vs_clear();
    drive(2'b01, 3'd1, 12'hFFF, 1'b0);
    tick();
    drive(2'b11, 3'd1, 12'hFFF, 1'b0);
    i_hw_set[1*WW + 4] = 1'b1;
    tick();
    i_hw_set = '0;
    vectors++; if (o_data !== 12'hFFF) begin $display("FAIL hwclr_resp got %h want FFF", o_data); errors++; end
    drive(2'b00, 3'd1, 12'h000, 1'b1);
    tick();
    vectors++; if (o_data !== 12'h010) begin $display("FAIL hwclr_rd got %h want 010", o_data); errors++; end
  endtask

  task automatic test_halt();
    drive(2'b00, 3'd3, 12'h000, 1'b1);
    tick();
    vectors++; if (o_freeze !== 1'b0) begin $display("FAIL freeze_low got %b want 0", o_freeze); errors++; end
    drive(2'b00, 3'd0, 12'h000, 1'b0);
    i_halt = 1'b1;
    i_hw_set[0] = 1'b1;
    #1;
    vectors++; if (o_freeze !== 1'b1) begin $display("FAIL freeze_high got %b want 1", o_freeze); errors++; end
    for (int c = 0; c < 3; c++) begin
      tick();
      i_hw_set = '0;
      vectors++; if (o_valid !== 1'b1) begin $display("FAIL halt_valid[%0d] got %b want 1", c, o_valid); errors++; end
      vectors++; if (o_tag !== 1'b1) begin $display("FAIL halt_tag[%0d] got %b want 1", c, o_tag); errors++; end
      vectors++; if (o_data !== 12'h000) begin $display("FAIL halt_data[%0d] got %h want 000", c, o_data); errors++; end
    end
    i_halt = 1'b0;
    tick();
    idle();
    vectors++; if (o_valid !== 1'b1) begin $display("FAIL rel_valid got %b want 1", o_valid); errors++; end
    vectors++; if (o_tag !== 1'b0) begin $display("FAIL rel_tag got %b want 0", o_tag); errors++; end
    vectors++; if (o_data !== 12'h001) begin $display("FAIL rel_data got %h want 001", o_data); errors++; end
    tick();
    vectors++; if (o_valid !== 1'b0) begin $display("FAIL rel_once got %b want 0", o_valid); errors++; end
  endtask

  task automatic test_reset_during_halt();
    drive(2'b00, 3'd2, 12'h000, 1'b1);
    tick();
    vectors++; if (o_valid !== 1'b1) begin $display("FAIL pend_valid got %b want 1", o_valid); errors++; end
    i_halt = 1'b1;
    srst   = 1'b1;
    i_hw_set = '1;
    tick();
    vectors++; if (o_valid !== 1'b0) begin $display("FAIL srst_halt_valid got %b want 0", o_valid); errors++; end
    vectors++; if (o_data !== 12'h000) begin $display("FAIL srst_halt_data got %h want 000", o_data); errors++; end
    srst = 1'b0; i_halt = 1'b0; i_hw_set = '0;
    // Back-to-back reads of every address; each response trails its request by one cycle.
    for (int a = 0; a < NR; a++) begin
      drive(2'b00, AW'(a), 12'h000, 1'b0);
      tick();
      vectors++; if (o_data !== 12'h000) begin $display("FAIL clr_reg[%0d] got %h want 000", a, o_data); errors++; end
      vectors++; if (r_data !== 12'h000) begin $display("FAIL clr_ro_reg[%0d] got %h want 000", a, r_data); errors++; end
    end
    idle();
    tick();
  endtask

  initial begin
    srst = 1'b1; i_tag = '0; i_addr = '0; i_data = '0; i_op = '0;
    i_valid = 1'b0; i_halt = 1'b0; i_hw_set = '0;
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_set_clear();
    test_hw_vs_clear();
    test_halt();
    test_reset_during_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/status_register_bank.md
Name: status_register_bank

Overview:
- Next-generation status register file for the instruction cache control path.
- Parametrised depth, width and tag. Adds four software op modes: read, write, set, write-1-to-clear.
- Adds per-bit hardware event inputs with sticky set, and a read-only bit mask.
- Single request port with a registered, tagged response. Sits between the cache controller's status/config request pipe and the cache datapath event sources.

Parameters:
- WORD_WIDTH, 12, bits per register.
- ADDR_WIDTH, 3, address bits; NUM_REGS = 2**ADDR_WIDTH registers.
- TAG_WIDTH, 1, width of the request tag carried to the response.
- RO_MASK, {NUM_REGS*WORD_WIDTH{1'b0}}, flattened per-bit mask. 1 = bit is software read-only; only reset and i_hw_set change it.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- srst  input  1  synchronous reset, active-high.
- i_tag  input  TAG_WIDTH  request tag.
- i_addr  input  ADDR_WIDTH  register index.
- i_data  input  WORD_WIDTH  write data or bit mask, depending on op.
- i_op  input  2  00 READ, 01 WRITE, 10 SET (OR), 11 CLEAR (write-1-to-clear).
- i_valid  input  1  request present.
- i_halt  input  1  downstream stall.
- i_hw_set  input  NUM_REGS*WORD_WIDTH  flattened per-bit hardware event. Register r occupies bits [r*WORD_WIDTH +: WORD_WIDTH].
- o_tag  output  TAG_WIDTH  tag of the accepted request.
- o_data  output  WORD_WIDTH  register value before the op was applied.
- o_op  output  2  op of the accepted request.
- o_valid  output  1  response valid.
- o_freeze_inputs  output  1  combinational copy of i_halt.

Behaviour:
- Clock and reset: one clock, clk. Reset srst is synchronous and active-high; it takes priority over everything, including i_halt and i_hw_set.
- Reset values: every register bit = 0; o_tag = 0; o_data = 0; o_op = 0; o_valid = 0.
- Accept: a request is accepted when i_valid & ~i_halt & ~srst.
- Response latency: 1 cycle. In the cycle after an accept:
  - o_valid = 1; o_tag = i_tag; o_op = i_op.
  - o_data = value of reg[i_addr] sampled before any update in the accept cycle, for all four ops.
- Idle: if ~i_halt and no accept, o_valid = 0 on the next edge; o_tag, o_data and o_op hold.
- Halt: while i_halt = 1, o_tag, o_data, o_op and o_valid all hold their values, and requests are ignored (not accepted, not queued). The upstream keeps its request stable because o_freeze_inputs = i_halt.
- Software update, applied only to reg[i_addr] on accept (sw_next); m = ~RO_MASK slice for that register:
  - READ: sw_next = reg.
  - WRITE: sw_next = (reg & ~m) | (i_data & m).
  - SET: sw_next = reg | (i_data & m).
  - CLEAR: sw_next = reg & ~(i_data & m).
  - All other registers: sw_next = reg.
- Hardware set: every cycle except reset, including while halted, reg_next = sw_next | i_hw_set slice. RO_MASK does not gate i_hw_set.
- Simultaneous events: a hardware set and a software clear/write of the same bit in the same cycle leave the bit at 1; hardware wins and no event is lost.
- Read-during-update: o_data never reflects same-cycle i_hw_set or the op's own effect. A READ in the cycle after a write to the same address returns the new value.
- No combinational path from inputs to outputs except i_halt -> o_freeze_inputs.
- Reset mid-operation: a response pending or held by halt is dropped; o_valid = 0 after the reset edge.
- Address range: every i_addr value is legal (full power-of-two decode); no wrap or error case.

Test Plan:
- Reset, then READ addr 5 -> one cycle later o_valid=1, o_data=0x000, o_tag echoes i_tag; next idle cycle o_valid=0.
- WRITE addr 2 data 0xABC, then READ addr 2 -> WRITE response o_data=0x000; READ response o_data=0xABC.
- With 0xABC in addr 2: SET 0x003, then CLEAR 0x0B0, then READ -> READ response o_data=0xA0F. Repeat with RO_MASK bits [3:0] of reg 2 set: the bit-0/1 SET is blocked and READ returns 0xA0C.
- Same cycle: CLEAR 0xFFF to addr 1 and i_hw_set bit 4 of reg 1 -> subsequent READ returns 0x010.
- Hold i_halt 3 cycles with i_valid=1 READ while pulsing i_hw_set on reg 0 bit 0 -> outputs frozen and no accept; after release, request accepted once and returns 0x001.
- Assert srst during halt with a pending response -> next edge o_valid=0 and all registers read 0.
